// File: rtl/piano_note_scheduler.sv
// Note scheduler between keyboard scanner and beeper: live last-press-wins
// arbitration with minimum gate, or timed autoplay from an external song ROM.
module piano_note_scheduler #(
  parameter int MIN_GATE_CYC = 600000,
  parameter int STEP_CYC     = 3000000,
  parameter int GAP_CYC      = 300000,
  parameter int SONG_LEN     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_held,
  input  logic [15:0] key_press,
  input  logic        play_mode,
  input  logic [4:0]  song_note,
  output logic [4:0]  song_addr,
  output logic [3:0]  note_idx,
  output logic        note_on,
  output logic        busy
);

  localparam int MAX_CNT = (MIN_GATE_CYC > STEP_CYC) ? MIN_GATE_CYC : STEP_CYC;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(MIN_GATE_CYC - 1);
  localparam logic [CNT_W-1:0] NOTE_END  = CNT_W'(STEP_CYC - GAP_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_END  = CNT_W'(STEP_CYC - 1);
  localparam logic [4:0]       LAST_ADDR = 5'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LIVE,
    AUTO_LOAD,
    AUTO_NOTE,
    AUTO_GAP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] gate_cnt, gate_cnt_nxt;
  logic [CNT_W-1:0] step_cnt, step_cnt_nxt;
  logic [4:0]       song_addr_nxt;
  logic [3:0]       note_idx_nxt;
  logic             note_on_nxt;
  logic             busy_nxt;

  // Multi-key ties always resolve to the highest set index.
  function automatic logic [3:0] highest(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gate_cnt  <= '0;
      step_cnt  <= '0;
      song_addr <= 5'd0;
      note_idx  <= 4'd0;
      note_on   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      gate_cnt  <= gate_cnt_nxt;
      step_cnt  <= step_cnt_nxt;
      song_addr <= song_addr_nxt;
      note_idx  <= note_idx_nxt;
      note_on   <= note_on_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    gate_cnt_nxt  = gate_cnt;
    step_cnt_nxt  = step_cnt;
    song_addr_nxt = song_addr;
    note_idx_nxt  = note_idx;
    note_on_nxt   = note_on;
    busy_nxt      = busy;

    case (state)
      IDLE: begin
        if (play_mode) begin
          state_nxt     = AUTO_LOAD;
          song_addr_nxt = 5'd0;
          busy_nxt      = 1'b1;
        end else if (key_press != 16'd0) begin
          state_nxt    = LIVE;
          note_idx_nxt = highest(key_press);
          note_on_nxt  = 1'b1;
          gate_cnt_nxt = GATE_LOAD;
        end
      end

      LIVE: begin
        // A fresh press beats both the gate and any release seen this cycle.
        if (play_mode) begin
          state_nxt     = AUTO_LOAD;
          note_on_nxt   = 1'b0;
          song_addr_nxt = 5'd0;
          busy_nxt      = 1'b1;
        end else if (key_press != 16'd0) begin
          note_idx_nxt = highest(key_press);
          gate_cnt_nxt = GATE_LOAD;
        end else if (gate_cnt == '0 && !key_held[note_idx]) begin
          if (key_held != 16'd0) begin
            note_idx_nxt = highest(key_held);
            gate_cnt_nxt = GATE_LOAD;
          end else begin
            note_on_nxt = 1'b0;
            state_nxt   = IDLE;
          end
        end else if (gate_cnt != '0) begin
          gate_cnt_nxt = gate_cnt - 1'b1;
        end
      end

      AUTO_LOAD: begin
        note_idx_nxt = song_note[3:0];
        note_on_nxt  = ~song_note[4];
        step_cnt_nxt = '0;
        state_nxt    = AUTO_NOTE;
      end

      AUTO_NOTE: begin
        step_cnt_nxt = step_cnt + 1'b1;
        if (step_cnt == NOTE_END) begin
          note_on_nxt = 1'b0;
          state_nxt   = AUTO_GAP;
        end
      end

      AUTO_GAP: begin
        step_cnt_nxt = step_cnt + 1'b1;
        if (step_cnt == STEP_END) begin
          song_addr_nxt = (song_addr == LAST_ADDR) ? 5'd0 : song_addr + 5'd1;
          state_nxt     = AUTO_LOAD;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Leaving autoplay discards the song position; held keys need a new press.
    if ((state == AUTO_LOAD || state == AUTO_NOTE || state == AUTO_GAP) && !play_mode) begin
      state_nxt     = IDLE;
      note_on_nxt   = 1'b0;
      busy_nxt      = 1'b0;
      song_addr_nxt = 5'd0;
      step_cnt_nxt  = '0;
    end
  end

endmodule

// File: tb/tb_piano_note_scheduler.sv
// Directed bench for piano_note_scheduler with shortened timing parameters
// and a combinational song ROM model.
module tb_piano_note_scheduler;

  localparam int MIN_GATE = 16;
  localparam int STEP     = 20;
  localparam int GAP      = 5;
  localparam int SLEN     = 32;

  logic        clk;
  logic        rst;
  logic [15:0] key_held;
  logic [15:0] key_press;
  logic        play_mode;
  logic [4:0]  song_note;
  logic [4:0]  song_addr;
  logic [3:0]  note_idx;
  logic        note_on;
  logic        busy;

  int checks;
  int fails;

  logic [4:0] rom [SLEN];

  piano_note_scheduler #(
    .MIN_GATE_CYC(MIN_GATE),
    .STEP_CYC    (STEP),
    .GAP_CYC     (GAP),
    .SONG_LEN    (SLEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_held (key_held),
    .key_press(key_press),
    .play_mode(play_mode),
    .song_note(song_note),
    .song_addr(song_addr),
    .note_idx (note_idx),
    .note_on  (note_on),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song: note 3, rest (idx 7), note 15, then a repeating pattern with rests every 8th entry.
  initial begin
    rom[0] = 5'h03;
    rom[1] = 5'h17;
    rom[2] = 5'h0F;
    for (int i = 3; i < SLEN; i++)
      rom[i] = {(i % 8) == 0, 4'(i % 16)};
  end

  always_comb song_note = rom[song_addr];

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({note_idx, note_on, song_addr, busy} !== 11'd0) begin
      fails++;
      $display("[TB] FAIL reset_values: got idx=%0d on=%0b addr=%0d busy=%0b, want all 0",
               note_idx, note_on, song_addr, busy);
    end
  endtask

  task automatic test_single_press();
    key_press = 16'h0010;
    key_held  = 16'h0010;
    tick();
    key_press = 16'h0000;
    checks++;
    if (note_idx !== 4'd4 || note_on !== 1'b1) begin
      fails++;
      $display("[TB] FAIL single_press_start: got idx=%0d on=%0b, want idx=4 on=1", note_idx, note_on);
    end
    for (int k = 1; k < MIN_GATE; k++) begin
      if (k == 5) key_held = 16'h0000;
      tick();
      checks++;
      if (note_on !== 1'b1) begin
        fails++;
        $display("[TB] FAIL single_press_gate: cycle %0d got on=%0b, want 1", k, note_on);
      end
    end
    tick();
    checks++;
    if (note_on !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_press_end: got on=%0b, want 0", note_on);
    end
  endtask

  task automatic test_fallback();
    key_press = 16'h0004;
    key_held  = 16'h0004;
    tick();
    key_press = 16'h0200;
    key_held  = 16'h0204;
    tick();
    key_press = 16'h0000;
    checks++;
    if (note_idx !== 4'd9 || note_on !== 1'b1) begin
      fails++;
      $display("[TB] FAIL last_press_wins: got idx=%0d on=%0b, want idx=9 on=1", note_idx, note_on);
    end
    repeat (MIN_GATE + 2) tick();
    checks++;
    if (note_idx !== 4'd9) begin
      fails++;
      $display("[TB] FAIL hold_after_gate: got idx=%0d, want 9", note_idx);
    end
    key_held = 16'h0004;
    tick();
    checks++;
    if (note_idx !== 4'd2 || note_on !== 1'b1) begin
      fails++;
      $display("[TB] FAIL fallback: got idx=%0d on=%0b, want idx=2 on=1", note_idx, note_on);
    end
    key_held = 16'h0000;
    repeat (MIN_GATE - 1) tick();
    checks++;
    if (note_on !== 1'b1) begin
      fails++;
      $display("[TB] FAIL fallback_gate: got on=%0b, want 1", note_on);
    end
    tick();
    checks++;
    if (note_on !== 1'b0) begin
      fails++;
      $display("[TB] FAIL release_all: got on=%0b, want 0", note_on);
    end
  endtask

  task automatic test_simultaneous();
    key_press = 16'h0105;
    key_held  = 16'h0105;
    tick();
    key_press = 16'h0000;
    key_held  = 16'h0000;
    checks++;
    if (note_idx !== 4'd8 || note_on !== 1'b1) begin
      fails++;
      $display("[TB] FAIL simultaneous: got idx=%0d on=%0b, want idx=8 on=1", note_idx, note_on);
    end
    repeat (MIN_GATE + 1) tick();
    checks++;
    if (note_on !== 1'b0) begin
      fails++;
      $display("[TB] FAIL simultaneous_end: got on=%0b, want 0", note_on);
    end
  endtask

  task automatic test_autoplay();
    logic [4:0] entry;
    logic       want_on;
    play_mode = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || song_addr !== 5'd0 || note_on !== 1'b0) begin
      fails++;
      $display("[TB] FAIL auto_start: got busy=%0b addr=%0d on=%0b, want 1/0/0", busy, song_addr, note_on);
    end
    for (int s = 0; s < SLEN; s++) begin
      entry = rom[s];
      for (int c = 0; c < STEP; c++) begin
        if (s == 1 && c == 3) begin
          key_press = 16'h8000;
          key_held  = 16'h8000;
        end else begin
          key_press = 16'h0000;
        end
        if (s == 2 && c == 0) key_held = 16'h0000;
        tick();
        want_on = (c < STEP - GAP) && !entry[4];
        checks++;
        if (note_on !== want_on || note_idx !== entry[3:0] || song_addr !== 5'(s) || busy !== 1'b1) begin
          fails++;
          $display("[TB] FAIL auto_step: s=%0d c=%0d got on=%0b idx=%0d addr=%0d busy=%0b, want on=%0b idx=%0d addr=%0d busy=1",
                   s, c, note_on, note_idx, song_addr, busy, want_on, entry[3:0], s);
        end
      end
      tick();
      checks++;
      if (note_on !== 1'b0 || song_addr !== 5'((s + 1) % SLEN)) begin
        fails++;
        $display("[TB] FAIL auto_advance: s=%0d got on=%0b addr=%0d, want on=0 addr=%0d",
                 s, note_on, song_addr, (s + 1) % SLEN);
      end
    end
  endtask

  task automatic test_abort();
    tick();
    repeat (4) tick();
    checks++;
    if (note_on !== 1'b1 || note_idx !== 4'd3) begin
      fails++;
      $display("[TB] FAIL abort_pre: got on=%0b idx=%0d, want on=1 idx=3", note_on, note_idx);
    end
    play_mode = 1'b0;
    key_held  = 16'h0020;
    tick();
    checks++;
    if (note_on !== 1'b0 || busy !== 1'b0 || song_addr !== 5'd0) begin
      fails++;
      $display("[TB] FAIL abort: got on=%0b busy=%0b addr=%0d, want 0/0/0", note_on, busy, song_addr);
    end
    repeat (3) tick();
    checks++;
    if (note_on !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_held_lockout: got on=%0b, want 0", note_on);
    end
    key_held = 16'h0000;
  endtask

  task automatic test_reset_mid();
    key_press = 16'h0040;
    key_held  = 16'h0040;
    tick();
    key_press = 16'h0000;
    checks++;
    if (note_on !== 1'b1 || note_idx !== 4'd6) begin
      fails++;
      $display("[TB] FAIL reset_mid_pre: got on=%0b idx=%0d, want on=1 idx=6", note_on, note_idx);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (note_on !== 1'b0 || note_idx !== 4'd0 || song_addr !== 5'd0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_live: got on=%0b idx=%0d addr=%0d busy=%0b, want all 0",
               note_on, note_idx, song_addr, busy);
    end
    repeat (3) tick();
    checks++;
    if (note_on !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_no_retrigger: got on=%0b, want 0", note_on);
    end
    key_held  = 16'h0000;
    play_mode = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || note_on !== 1'b0 || note_idx !== 4'd0 || song_addr !== 5'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid_song: got busy=%0b on=%0b idx=%0d addr=%0d, want all 0",
               busy, note_on, note_idx, song_addr);
    end
    play_mode = 1'b0;
    rst       = 1'b0;
    tick();
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    rst       = 1'b0;
    key_held  = 16'h0000;
    key_press = 16'h0000;
    play_mode = 1'b0;
    test_reset();
    test_single_press();
    test_fallback();
    test_simultaneous();
    test_autoplay();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
